diff_frame_sequencer: RTL and testbench
=======================================

// Module: diff_frame_sequencer
// PURPOSE
//   Sequences the per-bin spectral-difference store once per spectrum frame.
//   On a new frame it streams all bin magnitudes from the spectrum RAM into the diff store (write phase).
//   It then reads every difference back and offers it to the strip mapper over a valid/ready stream.
//   Sits between the spectrum RAM, the diff store and the LED strip mapper.
// PARAMETERS
//   NUM_BINS  40  bins per frame; indices 0..NUM_BINS-1
//   BIN_W     8   magnitude / difference width
//   ADDR_W    8   bin address width; NUM_BINS <= 2**ADDR_W
// PORTS
//   clk          in   1       clock
//   rst          in   1       reset, asynchronous, active-high
//   frame_valid  in   1       spectrum RAM holds a complete new frame; held until accepted
//   frame_ready  out  1       registered; 1 only in IDLE; frame accepted on frame_valid&&frame_ready
//   src_addr     out  ADDR_W  spectrum RAM read address (sync read, data valid next cycle)
//   src_data     in   BIN_W   spectrum RAM read data
//   diff_write   out  1       diff store write strobe
//   diff_addr    out  ADDR_W  diff store address (write and read)
//   diff_in      out  BIN_W   diff store write data = src_data (combinational pass-through)
//   diff_out     in   BIN_W   diff store read data, combinational from diff_addr
//   bin_valid    out  1       stream valid
//   bin_ready    in   1       stream ready from strip mapper
//   bin_idx      out  ADDR_W  bin index of bin_data
//   bin_data     out  BIN_W   difference value
//   frame_done   out  1       one-cycle pulse after last bin accepted
//   frame_cnt    out  16      frames completed, wraps 0xFFFF->0
// BEHAVIOUR
//   Reset: all outputs 0 (frame_ready 0), state IDLE; frame_ready rises on first clk edge after release.
//   States: IDLE -> UPDATE -> LOAD -> OFFER -> (LOAD | DONE) -> IDLE.
//   IDLE: frame_ready=1; on accept -> UPDATE, rd_idx=0, frame_ready=0.
//   UPDATE: lasts exactly NUM_BINS+1 cycles; cycle k (0..NUM_BINS):
//     src_addr=k for k<NUM_BINS; diff_write=1, diff_addr=k-1 for k>=1 (registered, one-stage pipe);
//     diff_in=src_data in those cycles. After the cycle with diff_addr=NUM_BINS-1 -> LOAD, idx=0.
//   LOAD: diff_write=0, diff_addr=idx; at cycle end bin_data<=diff_out, bin_idx<=idx, bin_valid<=1 -> OFFER.
//   OFFER: hold bin_valid/bin_idx/bin_data stable while !bin_ready.
//     On valid&&ready: bin_valid<=0; idx==NUM_BINS-1 -> DONE else idx+1 -> LOAD.
//     Throughput: at most 1 bin per 2 cycles.
//   DONE: frame_done=1 for one cycle, frame_cnt+1 -> IDLE (frame_ready=1 next cycle).
//   diff_write is never 1 outside UPDATE; diff_addr never >= NUM_BINS.
//   frame_valid outside IDLE is ignored (not accepted, not counted); source must hold it.
//   Latency: accept edge -> first bin_valid = NUM_BINS+2 cycles.
//   rst mid-frame: immediate abort to reset values. Partially written diff contents are not repaired.
//   The next accepted frame restarts from bin 0.
//   This block never clears the diff store; the shared rst does.
//   Index counters are ADDR_W wide, compare against NUM_BINS-1; no arithmetic wrap reached.
// STRUCTURE
//   music_strip_pkg: NUM_BINS, BIN_W, ADDR_W defaults, seq_state_t enum
//     (IDLE, UPDATE, LOAD, OFFER, DONE).
//   Single module, no sub-modules; the diff store and spectrum RAM are siblings in the parent.
// TESTING
//   1 rst held 5 cycles -> all outputs 0; after release frame_ready=1 next edge, frame_cnt=0.
//   2 RAM[i]=3*i, fresh diff store, one frame -> 40 beats bin_idx 0..39, bin_data=3*i;
//     first bin_valid 42 cycles after accept; frame_done once; frame_cnt=1.
//   3 Second frame RAM[i]=100 -> bin_data=|100-3*i| (idx0=100, idx33=1, idx39=17).
//   4 bin_ready random 30% duty -> bin_idx/bin_data stable while stalled; 40 unique in-order beats.
//   5 frame_valid held high continuously -> exactly one accept per frame; frame_ready only in IDLE.
//     diff_write pulses exactly 40 per frame.
//   6 rst asserted at UPDATE k=20 -> outputs 0 same cycle; next frame full 40 writes and 40 beats from idx 0.

Source files
------------

// File: rtl/music_strip_pkg.sv
// Shared sizing defaults and sequencer state encoding for the music strip datapath.
package music_strip_pkg;

    localparam int NUM_BINS = 40;
    localparam int BIN_W    = 8;
    localparam int ADDR_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        UPDATE,
        LOAD,
        OFFER,
        DONE
    } seq_state_t;

endpackage

// File: rtl/diff_frame_sequencer.sv
// Per-frame sequencer: streams spectrum bins into the diff store, then offers each
// stored difference to the strip mapper one bin at a time over valid/ready.
module diff_frame_sequencer
    import music_strip_pkg::*;
#(
    parameter int NUM_BINS = music_strip_pkg::NUM_BINS,
    parameter int BIN_W    = music_strip_pkg::BIN_W,
    parameter int ADDR_W   = music_strip_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_valid,
    output logic              frame_ready,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [BIN_W-1:0]  src_data,
    output logic              diff_write,
    output logic [ADDR_W-1:0] diff_addr,
    output logic [BIN_W-1:0]  diff_in,
    input  logic [BIN_W-1:0]  diff_out,
    output logic              bin_valid,
    input  logic              bin_ready,
    output logic [ADDR_W-1:0] bin_idx,
    output logic [BIN_W-1:0]  bin_data,
    output logic              frame_done,
    output logic [15:0]       frame_cnt
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BINS - 1);
    localparam logic [ADDR_W-1:0] LAST_K   = ADDR_W'(NUM_BINS);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              frame_ready_q, frame_ready_d;
    logic [ADDR_W-1:0] src_addr_q, src_addr_d;
    logic              diff_write_q, diff_write_d;
    logic [ADDR_W-1:0] diff_addr_q, diff_addr_d;
    logic              bin_valid_q, bin_valid_d;
    logic [ADDR_W-1:0] bin_idx_q, bin_idx_d;
    logic [BIN_W-1:0]  bin_data_q, bin_data_d;
    logic              frame_done_q, frame_done_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    // In UPDATE, idx_q counts cycles k = 0..NUM_BINS; the write lags the RAM read by one cycle.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        frame_ready_d = frame_ready_q;
        src_addr_d    = src_addr_q;
        diff_write_d  = 1'b0;
        diff_addr_d   = diff_addr_q;
        bin_valid_d   = bin_valid_q;
        bin_idx_d     = bin_idx_q;
        bin_data_d    = bin_data_q;
        frame_done_d  = 1'b0;
        frame_cnt_d   = frame_cnt_q;

        case (state_q)
            IDLE: begin
                frame_ready_d = 1'b1;
                if (frame_valid && frame_ready_q) begin
                    frame_ready_d = 1'b0;
                    state_d       = UPDATE;
                    idx_d         = '0;
                    src_addr_d    = '0;
                    diff_addr_d   = '0;
                end
            end
            UPDATE: begin
                if (idx_q == LAST_K) begin
                    state_d     = LOAD;
                    idx_d       = '0;
                    src_addr_d  = '0;
                    diff_addr_d = '0;
                end else begin
                    idx_d        = idx_q + ONE;
                    diff_write_d = 1'b1;
                    diff_addr_d  = idx_q;
                    src_addr_d   = (idx_q == LAST_IDX) ? '0 : idx_q + ONE;
                end
            end
            LOAD: begin
                bin_data_d  = diff_out;
                bin_idx_d   = idx_q;
                bin_valid_d = 1'b1;
                state_d     = OFFER;
            end
            OFFER: begin
                if (bin_ready) begin
                    bin_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d      = DONE;
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 16'd1;
                        diff_addr_d  = '0;
                    end else begin
                        idx_d       = idx_q + ONE;
                        diff_addr_d = idx_q + ONE;
                        state_d     = LOAD;
                    end
                end
            end
            DONE: begin
                frame_ready_d = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            frame_ready_q <= 1'b0;
            src_addr_q    <= '0;
            diff_write_q  <= 1'b0;
            diff_addr_q   <= '0;
            bin_valid_q   <= 1'b0;
            bin_idx_q     <= '0;
            bin_data_q    <= '0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            frame_ready_q <= frame_ready_d;
            src_addr_q    <= src_addr_d;
            diff_write_q  <= diff_write_d;
            diff_addr_q   <= diff_addr_d;
            bin_valid_q   <= bin_valid_d;
            bin_idx_q     <= bin_idx_d;
            bin_data_q    <= bin_data_d;
            frame_done_q  <= frame_done_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign frame_ready = frame_ready_q;
    assign src_addr    = src_addr_q;
    assign diff_write  = diff_write_q;
    assign diff_addr   = diff_addr_q;
    assign diff_in     = src_data;
    assign bin_valid   = bin_valid_q;
    assign bin_idx     = bin_idx_q;
    assign bin_data    = bin_data_q;
    assign frame_done  = frame_done_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_diff_frame_sequencer.sv
// Scoreboard bench for diff_frame_sequencer with behavioural spectrum RAM and diff store.
module tb_diff_frame_sequencer;

    localparam int NB = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_valid = 1'b0;
    logic        frame_ready;
    logic [7:0]  src_addr;
    logic [7:0]  src_data = 8'd0;
    logic        diff_write;
    logic [7:0]  diff_addr;
    logic [7:0]  diff_in;
    logic [7:0]  diff_out;
    logic        bin_valid;
    logic        bin_ready = 1'b1;
    logic [7:0]  bin_idx;
    logic [7:0]  bin_data;
    logic        frame_done;
    logic [15:0] frame_cnt;

    typedef struct packed {
        logic [7:0] idx;
        logic [7:0] data;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] ram[0:NB-1];
    logic [7:0] exp_data[0:NB-1];
    logic [7:0] store_prev[0:NB-1];
    logic [7:0] store_diff[0:NB-1];

    int  checks = 0;
    int  errors = 0;
    int  accept_cnt = 0;
    int  done_cnt = 0;
    int  wr_cnt = 0;
    bit  ready_random = 1'b0;
    bit  prev_valid = 1'b0;
    bit  prev_ready = 1'b0;
    logic [7:0] prev_idx = 8'd0;
    logic [7:0] prev_data = 8'd0;

    diff_frame_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .src_addr    (src_addr),
        .src_data    (src_data),
        .diff_write  (diff_write),
        .diff_addr   (diff_addr),
        .diff_in     (diff_in),
        .diff_out    (diff_out),
        .bin_valid   (bin_valid),
        .bin_ready   (bin_ready),
        .bin_idx     (bin_idx),
        .bin_data    (bin_data),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] abs_diff(input int a, input int b);
        return (a > b) ? 8'(a - b) : 8'(b - a);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Spectrum RAM: synchronous read.
    always @(posedge clk) src_data <= (src_addr < NB) ? ram[src_addr] : 8'd0;

    // Diff store: holds |new - previous| per bin, cleared by the shared reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NB; i++) begin
                store_prev[i] <= 8'd0;
                store_diff[i] <= 8'd0;
            end
        end else if (diff_write && diff_addr < NB) begin
            store_diff[diff_addr] <= abs_diff(int'(diff_in), int'(store_prev[diff_addr]));
            store_prev[diff_addr] <= diff_in;
        end
    end

    always_comb diff_out = (diff_addr < NB) ? store_diff[diff_addr] : 8'd0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            bin_ready = ready_random ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    // Monitor: write-phase ordering, stall stability and scoreboard pops.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (frame_valid && frame_ready) begin
                accept_cnt++;
                wr_cnt = 0;
            end
            if (frame_done) done_cnt++;
            if (diff_write) begin
                check_output("ready_during_write", frame_ready, 0);
                check_output("write_addr", diff_addr, wr_cnt);
                check_output("write_data", diff_in, (wr_cnt < NB) ? ram[wr_cnt] : 8'hxx);
                wr_cnt++;
            end
            if (bin_valid) check_output("ready_during_offer", frame_ready, 0);
            if (prev_valid && !prev_ready) begin
                check_output("stall_valid", bin_valid, 1);
                check_output("stall_idx", bin_idx, prev_idx);
                check_output("stall_data", bin_data, prev_data);
            end
            if (bin_valid && bin_ready) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_beat", 1, 0);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check_output("beat_idx", bin_idx, b.idx);
                    check_output("beat_data", bin_data, b.data);
                end
            end
            prev_valid = bin_valid;
            prev_ready = bin_ready;
            prev_idx   = bin_idx;
            prev_data  = bin_data;
        end
    end

    // One full frame: queue expected beats, hand the frame over, then wait for completion.
    task automatic apply_stimulus(input bit hold_valid, input int exp_cnt);
        bit got;
        int lat;
        int done_start;
        for (int i = 0; i < NB; i++) exp_q.push_back({8'(i), exp_data[i]});
        frame_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (frame_ready) got = 1'b1;
        end
        check_output("accept_timeout", got, 1);
        done_start = done_cnt;
        @(posedge clk);
        #1;
        if (!hold_valid) frame_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 100 && lat == 0; n++) begin
            @(posedge clk);
            #1;
            if (bin_valid) lat = n;
        end
        check_output("first_valid_latency", lat, NB + 2);
        got = 1'b0;
        for (int n = 0; n < 3000 && !got; n++) begin
            @(posedge clk);
            #1;
            if (frame_done) got = 1'b1;
        end
        check_output("done_timeout", got, 1);
        check_output("frame_cnt", frame_cnt, exp_cnt);
        check_output("writes_per_frame", wr_cnt, NB);
        check_output("beats_left", exp_q.size(), 0);
        @(posedge clk);
        #1;
        check_output("done_width", frame_done, 0);
        check_output("done_pulses", done_cnt - done_start, 1);
        for (int i = 0; i < NB; i++) ram[i] = ram[i];
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_frame_ready"}, frame_ready, 0);
        check_output({tag, "_src_addr"}, src_addr, 0);
        check_output({tag, "_diff_write"}, diff_write, 0);
        check_output({tag, "_diff_addr"}, diff_addr, 0);
        check_output({tag, "_bin_valid"}, bin_valid, 0);
        check_output({tag, "_bin_idx"}, bin_idx, 0);
        check_output({tag, "_bin_data"}, bin_data, 0);
        check_output({tag, "_frame_done"}, frame_done, 0);
        check_output({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < NB; i++) ram[i] = 8'(3 * i);
        repeat (5) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("ready_before_edge", frame_ready, 0);
        @(posedge clk);
        #1;
        check_output("ready_after_release", frame_ready, 1);
        check_output("cnt_after_release", frame_cnt, 0);

        $display("[TB] frame 1: ramp 3*i into fresh store");
        for (int i = 0; i < NB; i++) exp_data[i] = 8'(3 * i);
        apply_stimulus(1'b0, 1);

        $display("[TB] frame 2: flat 100");
        for (int i = 0; i < NB; i++) begin
            ram[i] = 8'd100;
            exp_data[i] = (i <= 33) ? 8'(100 - 3 * i) : 8'(3 * i - 100);
        end
        apply_stimulus(1'b0, 2);

        $display("[TB] frame 3: 255-i with 30%% ready");
        ready_random = 1'b1;
        for (int i = 0; i < NB; i++) begin
            ram[i] = 8'(255 - i);
            exp_data[i] = 8'(155 - i);
        end
        apply_stimulus(1'b0, 3);
        ready_random = 1'b0;

        $display("[TB] frames 4-5: frame_valid held high");
        accept_cnt = 0;
        for (int i = 0; i < NB; i++) begin
            ram[i] = 8'(5 * i);
            exp_data[i] = (6 * i >= 255) ? 8'(6 * i - 255) : 8'(255 - 6 * i);
        end
        apply_stimulus(1'b1, 4);
        for (int i = 0; i < NB; i++) exp_data[i] = 8'd0;
        apply_stimulus(1'b1, 5);
        frame_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("accepts_while_held", accept_cnt, 2);

        $display("[TB] frame 6: reset during write phase");
        for (int i = 0; i < NB; i++) ram[i] = 8'(i + 7);
        frame_valid = 1'b1;
        @(negedge clk);
        while (!frame_ready) @(negedge clk);
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_output("mid_update_src_addr", src_addr, 20);
        check_output("mid_update_diff_addr", diff_addr, 19);
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NB; i++) exp_data[i] = 8'(i + 7);
        apply_stimulus(1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
